// File: rtl/pla_seq_pkg.sv
// Shared types and defaults for the exhaustive PLA vector sequencer.
package pla_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        EMIT,
        DONE
    } seq_state_t;

    localparam int unsigned DEF_N_IN   = 10;
    localparam int unsigned DEF_WORD_W = 32;
    localparam int unsigned DEF_SETTLE = 1;

    // Number of truth-table words in a full sweep.
    function automatic int unsigned words(input int unsigned n_in, input int unsigned word_w);
        return (32'd1 << n_in) / word_w;
    endfunction

endpackage

// File: rtl/pla_word_packer.sv
// LSB-first shift register that assembles sampled netlist outputs into truth-table words.
module pla_word_packer #(
    parameter int unsigned WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              shift_i,
    input  logic              bit_i,
    output logic [WORD_W-1:0] data_o,
    output logic              full_o
);

    localparam int unsigned CNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else if (shift_i) begin
            data_q <= {bit_i, data_q[WORD_W-1:1]};
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    // Flags the shift that completes the word, so the FSM can branch in the same cycle.
    assign full_o = shift_i && (cnt_q == CNT_W'(WORD_W - 1));
    assign data_o = data_q;

endmodule

// File: rtl/pla_vector_sequencer.sv
// Walks every input vector of an N_IN-input function, samples the netlist output after
// a settle time and streams the packed truth table out over valid/ready.
module pla_vector_sequencer
    import pla_seq_pkg::*;
#(
    parameter int unsigned N_IN   = DEF_N_IN,
    parameter int unsigned WORD_W = DEF_WORD_W,
    parameter int unsigned SETTLE = DEF_SETTLE
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [N_IN-1:0]                  x_o,
    input  logic                             y_i,
    output logic                             word_valid,
    input  logic                             word_ready,
    output logic [WORD_W-1:0]                word_data,
    output logic [N_IN-$clog2(WORD_W)-1:0]   word_idx,
    output logic [N_IN:0]                    ones_count
);

    localparam int unsigned IDX_W = N_IN - $clog2(WORD_W);
    localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int unsigned WORDS = words(N_IN, WORD_W);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(WORDS - 1);
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);

    seq_state_t       state_q;
    logic             busy_q;
    logic             done_q;
    logic             valid_q;
    logic [N_IN-1:0]  x_q;
    logic [IDX_W-1:0] idx_q;
    logic [N_IN:0]    ones_q;
    logic [SET_W-1:0] settle_q;

    logic pk_clr;
    logic pk_shift;
    logic pk_full;

    always_comb begin
        pk_shift = (state_q == SAMPLE);
        pk_clr   = 1'b0;
        if (state_q == IDLE && start) begin
            pk_clr = 1'b1;
        end
        // The final word is kept visible after the sweep, so only intermediate handshakes clear.
        if (state_q == EMIT && word_ready && idx_q != LAST_IDX) begin
            pk_clr = 1'b1;
        end
    end

    pla_word_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (pk_clr),
        .shift_i (pk_shift),
        .bit_i   (y_i),
        .data_o  (word_data),
        .full_o  (pk_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            x_q      <= '0;
            idx_q    <= '0;
            ones_q   <= '0;
            settle_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= DRIVE;
                        busy_q   <= 1'b1;
                        x_q      <= '0;
                        idx_q    <= '0;
                        ones_q   <= '0;
                        settle_q <= '0;
                    end
                end
                DRIVE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_q  <= SAMPLE;
                        settle_q <= '0;
                    end else begin
                        settle_q <= settle_q + SET_W'(1);
                    end
                end
                SAMPLE: begin
                    ones_q <= ones_q + (N_IN + 1)'(y_i);
                    if (pk_full) begin
                        state_q <= EMIT;
                        valid_q <= 1'b1;
                    end else begin
                        x_q     <= x_q + N_IN'(1);
                        state_q <= DRIVE;
                    end
                end
                EMIT: begin
                    if (word_ready) begin
                        valid_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            x_q     <= x_q + N_IN'(1);
                            state_q <= DRIVE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign word_valid = valid_q;
    assign x_o        = x_q;
    assign word_idx   = idx_q;
    assign ones_count = ones_q;

endmodule

// File: tb/tb_pla_vector_sequencer.sv
// Self-checking bench: table-driven sweeps with a word scoreboard, plus stall/start/reset sequences.
module tb_pla_vector_sequencer;

    localparam int NW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_start, a_busy, a_done, a_y, a_valid, a_ready;
    logic [9:0]  a_x;
    logic [31:0] a_data;
    logic [4:0]  a_idx;
    logic [10:0] a_ones;

    logic        b_start, b_busy, b_done, b_y, b_valid, b_ready;
    logic [9:0]  b_x, b_xd1, b_xd2;
    logic [31:0] b_data;
    logic [4:0]  b_idx;
    logic [10:0] b_ones;

    int checks = 0;
    int errors = 0;
    int mode   = 0;
    localparam int MODE_B = 4;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    logic [31:0] cap [NW];
    int          ncap;

    typedef struct {
        int          mode;
        int          stall;
        bit          pulse;
        int          cyc;
        int          ones;
        logic [31:0] w0;
    } vec_t;
    vec_t tbl [6];

    function automatic logic model_y(input int m, input logic [9:0] x);
        case (m)
            0:       return x[0];
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return ^x;
            default: return x[0] ^ x[3] ^ (x[7] & x[2]) ^ x[9];
        endcase
    endfunction

    function automatic logic [31:0] model_word(input int m, input int w);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) r[k] = model_y(m, 10'(w * 32 + k));
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    assign a_y = model_y(mode, a_x);

    always @(posedge clk) begin
        b_xd1 <= b_x;
        b_xd2 <= b_xd1;
    end
    assign b_y = model_y(MODE_B, b_xd2);

    pla_vector_sequencer dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (a_start),
        .busy       (a_busy),
        .done       (a_done),
        .x_o        (a_x),
        .y_i        (a_y),
        .word_valid (a_valid),
        .word_ready (a_ready),
        .word_data  (a_data),
        .word_idx   (a_idx),
        .ones_count (a_ones)
    );

    pla_vector_sequencer #(
        .N_IN   (10),
        .WORD_W (32),
        .SETTLE (3)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (b_start),
        .busy       (b_busy),
        .done       (b_done),
        .x_o        (b_x),
        .y_i        (b_y),
        .word_valid (b_valid),
        .word_ready (b_ready),
        .word_data  (b_data),
        .word_idx   (b_idx),
        .ones_count (b_ones)
    );

    always @(negedge clk) begin
        if (rst_n && a_valid && a_ready) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_word: got idx %0d expected no word", a_idx);
            end else begin
                ea = qa.pop_front();
                chk("a_word_idx", a_idx, ea.idx);
                chk("a_word_data", a_data, ea.data);
                cap[a_idx] = a_data;
                ncap++;
            end
        end
        if (rst_n && b_valid && b_ready) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_word: got idx %0d expected no word", b_idx);
            end else begin
                eb = qb.pop_front();
                chk("b_word_idx", b_idx, eb.idx);
                chk("b_word_data", b_data, eb.data);
            end
        end
    end

    task automatic push_a(input int m);
        exp_t e;
        for (int w = 0; w < NW; w++) begin
            e.idx  = 5'(w);
            e.data = model_word(m, w);
            qa.push_back(e);
        end
    endtask

    // Runs one sweep on dut_a; returns at #1 after the edge that raises done.
    task automatic sweep(input int m, input int stall_idx, input bit pulse,
                         input int exp_cyc, input int exp_ones, input logic [31:0] exp_w0);
        int          n;
        bit          finished;
        int          stall_left;
        bit          stall_seen;
        bit          pulsed;
        logic [31:0] hold_w;
        mode = m;
        ncap = 0;
        push_a(m);
        @(negedge clk);
        a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        chk("accept_busy", a_busy, 1);
        chk("accept_x", a_x, 0);
        chk("accept_ones", a_ones, 0);
        chk("accept_idx", a_idx, 0);
        n = 0;
        finished = 1'b0;
        stall_left = (stall_idx >= 0) ? 5 : 0;
        stall_seen = 1'b0;
        pulsed = 1'b0;
        hold_w = '0;
        while (!finished && n < 6000) begin
            @(posedge clk);
            n++;
            #1;
            if (a_done) begin
                finished = 1'b1;
            end else begin
                if (pulse && a_start) a_start = 1'b0;
                else if (pulse && !pulsed && a_x == 10'd300) begin
                    a_start = 1'b1;
                    pulsed = 1'b1;
                end
                if (stall_left > 0 && a_valid && int'(a_idx) == stall_idx) begin
                    if (stall_left == 5) hold_w = a_data;
                    a_ready = 1'b0;
                    stall_left--;
                end else begin
                    if (stall_idx >= 0 && stall_left == 0 && !stall_seen && a_valid
                        && int'(a_idx) == stall_idx) begin
                        stall_seen = 1'b1;
                        chk("stall_x_frozen", a_x, 127);
                        chk("stall_data_frozen", a_data, hold_w);
                    end
                    a_ready = 1'b1;
                end
            end
        end
        a_start = 1'b0;
        a_ready = 1'b1;
        chk("sweep_finished", finished, 1);
        chk("sweep_cycles", n, exp_cyc);
        chk("done_busy_low", a_busy, 0);
        chk("ones_count", a_ones, exp_ones);
        chk("words_seen", ncap, NW);
        chk("word0", cap[0], exp_w0);
        chk("queue_empty", qa.size(), 0);
        if (stall_idx >= 0) chk("stall_observed", stall_seen, 1);
        if (pulse) chk("pulse_issued", pulsed, 1);
    endtask

    task automatic sweep_b();
        int   n;
        bit   finished;
        int   exp_ones;
        exp_t e;
        exp_ones = 0;
        for (int x = 0; x < 1024; x++) exp_ones += int'(model_y(MODE_B, 10'(x)));
        for (int w = 0; w < NW; w++) begin
            e.idx  = 5'(w);
            e.data = model_word(MODE_B, w);
            qb.push_back(e);
        end
        @(negedge clk);
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        chk("b_accept_busy", b_busy, 1);
        n = 0;
        finished = 1'b0;
        while (!finished && n < 6000) begin
            @(posedge clk);
            n++;
            #1;
            if (b_done) finished = 1'b1;
        end
        chk("b_finished", finished, 1);
        chk("b_cycles", n, 4 * 1024 + 32);
        chk("b_ones", b_ones, exp_ones);
        chk("b_queue_empty", qb.size(), 0);
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        a_start = 1'b0;
        a_ready = 1'b1;
        b_start = 1'b0;
        b_ready = 1'b1;

        tbl[0] = '{mode: 0, stall: -1, pulse: 1'b0, cyc: 2080, ones: 512,  w0: 32'hAAAAAAAA};
        tbl[1] = '{mode: 1, stall: -1, pulse: 1'b0, cyc: 2080, ones: 1024, w0: 32'hFFFFFFFF};
        tbl[2] = '{mode: 2, stall: -1, pulse: 1'b0, cyc: 2080, ones: 0,    w0: 32'h00000000};
        tbl[3] = '{mode: 3, stall: -1, pulse: 1'b0, cyc: 2080, ones: 512,  w0: 32'h96696996};
        tbl[4] = '{mode: 0, stall: 3,  pulse: 1'b0, cyc: 2085, ones: 512,  w0: 32'hAAAAAAAA};
        tbl[5] = '{mode: 3, stall: -1, pulse: 1'b1, cyc: 2080, ones: 512,  w0: 32'h96696996};

        #2;
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_valid", a_valid, 0);
        chk("rst_x", a_x, 0);
        chk("rst_data", a_data, 0);
        chk("rst_idx", a_idx, 0);
        chk("rst_ones", a_ones, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_reset", a_busy, 0);

        for (int i = 0; i < 6; i++) begin
            sweep(tbl[i].mode, tbl[i].stall, tbl[i].pulse, tbl[i].cyc, tbl[i].ones, tbl[i].w0);
            if (tbl[i].mode == 3) chk("parity_word1", cap[1], 32'h69969669);
            @(posedge clk);
            #1;
            chk("done_one_cycle", a_done, 0);
            chk("ones_held", a_ones, tbl[i].ones);
            chk("idx_held", a_idx, 31);
        end

        // start held through the DONE cycle: ignored there, accepted on the following edge
        sweep(0, -1, 1'b0, 2080, 512, 32'hAAAAAAAA);
        push_a(0);
        a_start = 1'b1;
        @(posedge clk);
        #1;
        chk("start_in_done_ignored", a_busy, 0);
        @(posedge clk);
        #1;
        a_start = 1'b0;
        chk("start_after_done_busy", a_busy, 1);
        chk("start_after_done_x", a_x, 0);
        n = 0;
        while (a_x != 10'd300 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("reach_x300", a_x, 300);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", a_busy, 0);
        chk("midrst_done", a_done, 0);
        chk("midrst_valid", a_valid, 0);
        chk("midrst_x", a_x, 0);
        chk("midrst_data", a_data, 0);
        chk("midrst_idx", a_idx, 0);
        chk("midrst_ones", a_ones, 0);
        @(posedge clk);
        #1;
        chk("midrst_held_idle", a_busy, 0);
        rst_n = 1'b1;
        qa.delete();
        @(posedge clk);
        #1;
        chk("idle_after_midrst", a_x, 0);
        sweep(3, -1, 1'b0, 2080, 512, 32'h96696996);
        chk("parity_word1_after_rst", cap[1], 32'h69969669);

        sweep_b();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
